// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : APB initiator. Converts single core-side requests into APB
//                SETUP/ACCESS transfers to NUM_SLAVES peripherals, decodes the
//                target slave from the address, and reports unmapped accesses
//                and PREADY timeouts as error responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
   parameter int          NUM_SLAVES  = 4,
   parameter logic [3:0]  BASE_NIBBLE = 4'h1,
   parameter int          TIMEOUT     = 16
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [31:0]                req_addr,
   input  logic [31:0]                req_wdata,
   output logic                       rsp_valid,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_err,
   output logic [31:0]                PADDR,
   output logic                       PWRITE,
   output logic [31:0]                PWDATA,
   output logic                       PENABLE,
   output logic [NUM_SLAVES-1:0]      PSEL,
   input  logic [32*NUM_SLAVES-1:0]   PRDATA,
   input  logic [NUM_SLAVES-1:0]      PREADY
);

   localparam int c_CNT_W = $clog2(TIMEOUT);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_SETUP  = 2'd1;
   localparam logic [1:0] c_ACCESS = 2'd2;
   localparam logic [1:0] c_RESP   = 2'd3;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [3:0]             r_idx;
   logic                   r_mapped;
   logic [c_CNT_W-1:0]     r_cnt;

   logic [3:0]             w_idx_nxt;
   logic                   w_mapped_nxt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;
   logic [31:0]            w_paddr_nxt;
   logic                   w_pwrite_nxt;
   logic [31:0]            w_pwdata_nxt;
   logic                   w_penable_nxt;
   logic [NUM_SLAVES-1:0]  w_psel_nxt;
   logic                   w_rsp_valid_nxt;
   logic                   w_rsp_err_nxt;
   logic [31:0]            w_rsp_rdata_nxt;

   logic                   w_accept;
   logic [3:0]             w_req_idx;
   logic                   w_req_mapped;
   logic [NUM_SLAVES-1:0]  w_req_onehot;
   logic                   w_ready_sel;
   logic [31:0]            w_prdata_sel;
   logic                   w_timeout;

   assign req_ready    = (r_state == c_IDLE);
   assign w_accept     = req_valid && req_ready;
   assign w_req_idx    = req_addr[15:12];
   assign w_req_mapped = (req_addr[31:28] == BASE_NIBBLE) &&
                         ({1'b0, w_req_idx} < 5'(NUM_SLAVES));
   assign w_req_onehot = NUM_SLAVES'(1) << w_req_idx;
   // Last permitted ACCESS cycle without PREADY
   assign w_timeout    = (r_cnt == c_CNT_W'(TIMEOUT - 1));

   // Pick PREADY/PRDATA of the latched slave only; other slaves are ignored
   always_comb begin
      w_ready_sel  = 1'b0;
      w_prdata_sel = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (r_idx == 4'(k)) begin
            w_ready_sel  = PREADY[k];
            w_prdata_sel = PRDATA[32*k +: 32];
         end
      end
   end

   // State and registered outputs; reset drops PSEL/PENABLE immediately
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state   <= c_IDLE;
         r_idx     <= '0;
         r_mapped  <= 1'b0;
         r_cnt     <= '0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PENABLE   <= 1'b0;
         PSEL      <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_mapped  <= w_mapped_nxt;
         r_cnt     <= w_cnt_nxt;
         PADDR     <= w_paddr_nxt;
         PWRITE    <= w_pwrite_nxt;
         PWDATA    <= w_pwdata_nxt;
         PENABLE   <= w_penable_nxt;
         PSEL      <= w_psel_nxt;
         rsp_valid <= w_rsp_valid_nxt;
         rsp_err   <= w_rsp_err_nxt;
         rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   // Next-state: unmapped requests pass through SETUP without PSEL, then RESP
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:   if (w_accept) w_state_nxt = c_SETUP;
         c_SETUP:  w_state_nxt = r_mapped ? c_ACCESS : c_RESP;
         c_ACCESS: if (w_ready_sel || w_timeout) w_state_nxt = c_RESP;
         c_RESP:   w_state_nxt = c_IDLE;
         default:  w_state_nxt = c_IDLE;
      endcase
   end

   // Next values of the registered APB and response outputs
   always_comb begin
      w_idx_nxt       = r_idx;
      w_mapped_nxt    = r_mapped;
      w_cnt_nxt       = r_cnt;
      w_paddr_nxt     = PADDR;
      w_pwrite_nxt    = PWRITE;
      w_pwdata_nxt    = PWDATA;
      w_penable_nxt   = PENABLE;
      w_psel_nxt      = PSEL;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = rsp_err;
      w_rsp_rdata_nxt = rsp_rdata;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               w_idx_nxt    = w_req_idx;
               w_mapped_nxt = w_req_mapped;
               w_paddr_nxt  = req_addr;
               w_pwrite_nxt = req_write;
               w_pwdata_nxt = req_wdata;
               w_psel_nxt   = w_req_mapped ? w_req_onehot : '0;
            end
         end
         c_SETUP: begin
            if (r_mapped) begin
               w_penable_nxt = 1'b1;
               w_cnt_nxt     = '0;
            end else begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_rdata_nxt = '0;
            end
         end
         c_ACCESS: begin
            if (w_ready_sel) begin
               w_psel_nxt      = '0;
               w_penable_nxt   = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b0;
               w_rsp_rdata_nxt = PWRITE ? 32'h0 : w_prdata_sel;
            end else if (w_timeout) begin
               w_psel_nxt      = '0;
               w_penable_nxt   = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_rdata_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Directed self-checking bench for apb_master_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

   logic         PCLK = 1'b0;
   logic         PRESETn;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [31:0]  req_addr;
   logic [31:0]  req_wdata;
   logic         rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;
   logic [31:0]  PADDR;
   logic         PWRITE;
   logic [31:0]  PWDATA;
   logic         PENABLE;
   logic [3:0]   PSEL;
   logic [127:0] PRDATA;
   logic [3:0]   PREADY;

   int n_assert = 0;
   int n_fail   = 0;
   int n_rsp    = 0;
   int rsp_mark;
   int pen_cycles;

   apb_master_bridge #(
      .NUM_SLAVES  (4),
      .BASE_NIBBLE (4'h1),
      .TIMEOUT     (16)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PADDR     (PADDR),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PENABLE   (PENABLE),
      .PSEL      (PSEL),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY)
   );

   always #5 PCLK = ~PCLK;

   // Count every response pulse seen
   always @(negedge PCLK) if (rsp_valid === 1'b1) n_rsp++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; sample and drive on the falling edge
   task automatic tick();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
   endtask

   initial begin
      PRESETn   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      PRDATA    = '0;
      PREADY    = '0;
      #12;
      // ---------------- reset state ----------------
      chk("rst_psel",    PSEL,      0);
      chk("rst_penable", PENABLE,   0);
      chk("rst_paddr",   PADDR,     0);
      chk("rst_pwrite",  PWRITE,    0);
      chk("rst_pwdata",  PWDATA,    0);
      chk("rst_rspv",    rsp_valid, 0);
      chk("rst_err",     rsp_err,   0);
      chk("rst_rdata",   rsp_rdata, 0);
      chk("rst_ready",   req_ready, 1);
      @(negedge PCLK);
      PRESETn = 1'b1;
      tick();

      // ---------------- 1: write, registered-ready slave 1 ----------------
      request(1'b1, 32'h1000_1004, 32'h0000_00A5);
      chk("t1_ready_T0", req_ready, 1);
      tick(); req_valid = 1'b0;
      chk("t1_psel_T1",    PSEL,    4'b0010);
      chk("t1_pen_T1",     PENABLE, 0);
      chk("t1_paddr_T1",   PADDR,   32'h1000_1004);
      chk("t1_pwrite_T1",  PWRITE,  1);
      chk("t1_pwdata_T1",  PWDATA,  32'hA5);
      chk("t1_ready_T1",   req_ready, 0);
      tick();
      chk("t1_psel_T2",    PSEL,    4'b0010);
      chk("t1_pen_T2",     PENABLE, 1);
      chk("t1_rspv_T2",    rsp_valid, 0);
      tick();
      chk("t1_psel_T3",    PSEL,    4'b0010);
      chk("t1_pen_T3",     PENABLE, 1);
      chk("t1_pwdata_T3",  PWDATA,  32'hA5);
      PREADY = 4'b0010;
      tick(); PREADY = 4'b0000;
      chk("t1_rspv_T4",    rsp_valid, 1);
      chk("t1_err_T4",     rsp_err,   0);
      chk("t1_rdata_T4",   rsp_rdata, 0);
      chk("t1_psel_T4",    PSEL,      0);
      chk("t1_pen_T4",     PENABLE,   0);
      chk("t1_pwdata_T4",  PWDATA,    32'hA5);
      tick();
      chk("t1_rspv_T5",    rsp_valid, 0);
      chk("t1_ready_T5",   req_ready, 1);

      // ---------------- 2: read, zero-wait slave 0 ----------------
      PRDATA[31:0] = 32'hDEAD_BEEF;
      PREADY       = 4'b0001;
      request(1'b0, 32'h1000_0000, 32'h0);
      tick(); req_valid = 1'b0;
      chk("t2_psel_T1",  PSEL,    4'b0001);
      chk("t2_pen_T1",   PENABLE, 0);
      tick();
      chk("t2_pen_T2",   PENABLE, 1);
      chk("t2_rspv_T2",  rsp_valid, 0);
      tick();
      chk("t2_rspv_T3",  rsp_valid, 1);
      chk("t2_rdata_T3", rsp_rdata, 32'hDEAD_BEEF);
      chk("t2_err_T3",   rsp_err,   0);
      tick();
      PREADY = 4'b0000;
      chk("t2_rspv_T4",  rsp_valid, 0);
      chk("t2_hold_T4",  rsp_rdata, 32'hDEAD_BEEF);

      // ---------------- 3: unmapped accesses ----------------
      request(1'b0, 32'h2000_0000, 32'h0);
      tick(); req_valid = 1'b0;
      chk("t3a_psel_T1", PSEL,      0);
      chk("t3a_rspv_T1", rsp_valid, 0);
      tick();
      chk("t3a_rspv_T2", rsp_valid, 1);
      chk("t3a_err_T2",  rsp_err,   1);
      chk("t3a_rdat_T2", rsp_rdata, 0);
      chk("t3a_psel_T2", PSEL,      0);
      tick();
      chk("t3a_rspv_T3", rsp_valid, 0);
      chk("t3a_rdy_T3",  req_ready, 1);
      PRDATA[31:0] = 32'h1111_2222;
      request(1'b0, 32'h1000_5000, 32'h0);
      tick(); req_valid = 1'b0;
      chk("t3b_psel_T1", PSEL,      0);
      tick();
      chk("t3b_rspv_T2", rsp_valid, 1);
      chk("t3b_err_T2",  rsp_err,   1);
      chk("t3b_rdat_T2", rsp_rdata, 0);
      chk("t3b_pen_T2",  PENABLE,   0);
      tick();

      // ---------------- 4: timeout on slave 2, PREADY[3] noise ----------------
      PRDATA[127:96] = 32'h3333_3333;
      request(1'b0, 32'h1000_2000, 32'h0);
      tick(); req_valid = 1'b0;
      chk("t4_psel_T1", PSEL, 4'b0100);
      tick();
      pen_cycles = 0;
      for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
         if (PENABLE === 1'b1) pen_cycles++;
         PREADY = (i % 2 == 1) ? 4'b1000 : 4'b0000;
         tick();
      end
      PREADY = 4'b0000;
      chk("t4_pen_cycles", pen_cycles, 16);
      chk("t4_rspv",       rsp_valid,  1);
      chk("t4_err",        rsp_err,    1);
      chk("t4_rdata",      rsp_rdata,  0);
      chk("t4_psel",       PSEL,       0);
      chk("t4_pen",        PENABLE,    0);
      tick();

      // ---------------- 5: req_valid held for two requests ----------------
      rsp_mark       = n_rsp;
      PRDATA[31:0]   = 32'h1234_5678;
      PRDATA[63:32]  = 32'hCAFE_0001;
      PREADY         = 4'b0011;
      request(1'b0, 32'h1000_0010, 32'h0);
      tick();
      request(1'b0, 32'h1000_1020, 32'h0);
      chk("t5_psel_T1",  PSEL,      4'b0001);
      chk("t5_rdy_T1",   req_ready, 0);
      tick();
      chk("t5_psel_T2",  PSEL,      4'b0001);
      chk("t5_paddr_T2", PADDR,     32'h1000_0010);
      tick();
      chk("t5_rspv_T3",  rsp_valid, 1);
      chk("t5_rdata_T3", rsp_rdata, 32'h1234_5678);
      tick();
      chk("t5_rdy_T4",   req_ready, 1);
      chk("t5_psel_T4",  PSEL,      0);
      tick(); req_valid = 1'b0;
      chk("t5_psel_T5",  PSEL,      4'b0010);
      chk("t5_paddr_T5", PADDR,     32'h1000_1020);
      tick();
      tick();
      chk("t5_rspv_T7",  rsp_valid, 1);
      chk("t5_rdata_T7", rsp_rdata, 32'hCAFE_0001);
      tick(); tick(); tick();
      PREADY = 4'b0000;
      chk("t5_pulses",   n_rsp - rsp_mark, 2);

      // ---------------- 6: reset during ACCESS ----------------
      request(1'b0, 32'h1000_2000, 32'h0);
      tick(); req_valid = 1'b0;
      tick();
      chk("t6_pen_T2",   PENABLE, 1);
      rsp_mark = n_rsp;
      #1 PRESETn = 1'b0;
      #1;
      chk("t6_psel_rst", PSEL,      0);
      chk("t6_pen_rst",  PENABLE,   0);
      chk("t6_rdy_rst",  req_ready, 1);
      chk("t6_addr_rst", PADDR,     0);
      tick();
      PRESETn = 1'b1;
      tick(); tick();
      chk("t6_no_rsp",   n_rsp - rsp_mark, 0);
      chk("t6_rdy_post", req_ready, 1);
      PRDATA[127:96] = 32'h0BAD_F00D;
      PREADY         = 4'b1000;
      request(1'b0, 32'h1000_3000, 32'h0);
      tick(); req_valid = 1'b0;
      chk("t6_psel_T1",  PSEL, 4'b1000);
      tick(); tick();
      chk("t6_rspv_T3",  rsp_valid, 1);
      chk("t6_rdata_T3", rsp_rdata, 32'h0BAD_F00D);
      chk("t6_err_T3",   rsp_err,   0);
      tick();
      PREADY = 4'b0000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
